// File: rtl/key_debounce_pkg.sv
// Shared constants and helpers for the push-button debounce block.
package key_debounce_pkg;

    localparam logic KEY_RELEASED            = 1'b1;
    localparam logic KEY_PRESSED             = 1'b0;
    localparam int   DEFAULT_DEBOUNCE_CYCLES = 500000;

    function automatic int cnt_width(int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/key_debounce_lane.sv
// One key lane: two-flop synchroniser, stable-time counter, debounced level and edge strobes.
module key_debounce_lane
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw_n,
    output logic key_db_n,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int              CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          db;
    logic [CW-1:0] cnt;
    logic          press_q;
    logic          release_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= KEY_RELEASED;
            s2        <= KEY_RELEASED;
            db        <= KEY_RELEASED;
            cnt       <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1        <= key_raw_n;
            s2        <= s1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            // Any sample agreeing with the current level restarts the stable-time count.
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db  <= s2;
                cnt <= '0;
                if (s2 == KEY_PRESSED) begin
                    press_q <= 1'b1;
                end else begin
                    release_q <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign key_db_n      = db;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces N_KEYS active-low board keys; each lane is independent.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys_raw_n,
    output logic [N_KEYS-1:0] keys_db_n,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 24)) begin : g_bad_cycles
        $error("key_debounce: DEBOUNCE_CYCLES must be in 2 .. 2^24");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
        key_debounce_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_lane (
            .clk           (clk),
            .reset         (reset),
            .key_raw_n     (keys_raw_n[i]),
            .key_db_n      (keys_db_n[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with N_KEYS=3, DEBOUNCE_CYCLES=8.
module tb_key_debounce;

    localparam int N  = 3;
    localparam int DC = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] keys_raw_n;
    logic [N-1:0] keys_db_n;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;

    int n_vec = 0;
    int n_err = 0;

    key_debounce #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .keys_raw_n    (keys_raw_n),
        .keys_db_n     (keys_db_n),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares {press, release, db} against the expected triple.
    task automatic check(input string tag, input logic [N-1:0] p, input logic [N-1:0] r,
                         input logic [N-1:0] db);
        logic [3*N-1:0] obs;
        logic [3*N-1:0] exp;
        obs = {press_pulse, release_pulse, keys_db_n};
        exp = {p, r, db};
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: press/release/db observed %b/%b/%b expected %b/%b/%b",
                   tag, press_pulse, release_pulse, keys_db_n, p, r, db);
        end
    endtask

    task automatic quiet(input int n, input string tag, input logic [N-1:0] db);
        repeat (n) begin
            tick();
            check(tag, '0, '0, db);
        end
    endtask

    // One edge carrying the strobe, then one edge with strobes cleared.
    task automatic pulse(input string tag, input logic [N-1:0] p, input logic [N-1:0] r,
                         input logic [N-1:0] db);
        tick();
        check(tag, p, r, db);
        tick();
        check({tag, "_after"}, '0, '0, db);
    endtask

    initial begin
        // Reset with keys 0 and 2 held
        reset      = 1'b1;
        keys_raw_n = 3'b010;
        quiet(3, "reset_hold", 3'b111);
        reset = 1'b0;
        quiet(DC + 1, "reset_release", 3'b111);
        pulse("reset_held_press", 3'b101, 3'b000, 3'b010);
        keys_raw_n = 3'b111;
        quiet(DC + 1, "reset_keys_up", 3'b010);
        pulse("reset_keys_release", 3'b000, 3'b101, 3'b111);

        // Clean press/release on key 0, held low for 20 cycles
        keys_raw_n = 3'b110;
        quiet(DC + 1, "k0_fall", 3'b111);
        pulse("k0_press", 3'b001, 3'b000, 3'b110);
        quiet(9, "k0_hold", 3'b110);
        keys_raw_n = 3'b111;
        quiet(DC + 1, "k0_rise", 3'b110);
        pulse("k0_release", 3'b000, 3'b001, 3'b111);

        // Bounce on key 1: 3-cycle low/high runs for 30 cycles, then hold low
        for (int i = 0; i < 5; i++) begin
            keys_raw_n = 3'b101;
            quiet(3, "k1_bounce_lo", 3'b111);
            keys_raw_n = 3'b111;
            quiet(3, "k1_bounce_hi", 3'b111);
        end
        keys_raw_n = 3'b101;
        quiet(DC + 1, "k1_settle", 3'b111);
        pulse("k1_press", 3'b010, 3'b000, 3'b101);
        keys_raw_n = 3'b111;
        quiet(DC + 1, "k1_rise", 3'b101);
        pulse("k1_release", 3'b000, 3'b010, 3'b111);

        // Glitch of DEBOUNCE_CYCLES-1 on key 2 must be rejected
        keys_raw_n = 3'b011;
        quiet(DC - 1, "k2_glitch_lo", 3'b111);
        keys_raw_n = 3'b111;
        quiet(12, "k2_glitch_hi", 3'b111);

        // All keys drop together
        keys_raw_n = 3'b000;
        quiet(DC + 1, "all_fall", 3'b111);
        pulse("all_press", 3'b111, 3'b000, 3'b000);
        keys_raw_n = 3'b111;
        quiet(DC + 1, "all_rise", 3'b000);
        pulse("all_release", 3'b000, 3'b111, 3'b111);

        // Reset 5 cycles into a key-0 press, key kept held
        keys_raw_n = 3'b110;
        quiet(5, "midcnt_count", 3'b111);
        reset = 1'b1;
        quiet(2, "midcnt_reset", 3'b111);
        reset = 1'b0;
        quiet(DC + 1, "midcnt_restart", 3'b111);
        pulse("midcnt_press", 3'b001, 3'b000, 3'b110);
        keys_raw_n = 3'b111;
        quiet(DC + 1, "midcnt_rise", 3'b110);
        pulse("midcnt_release", 3'b000, 3'b001, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
